// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan chain sequencing controller.
package scan_ctrl_pkg;

    localparam int unsigned SCAN_CHAIN_LEN_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESET  = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_UNLOAD  = 3'd4,
        ST_DONE    = 3'd5
    } scan_state_e;

    // Cycles from the start cycle (counted as 1) to the done-high cycle.
    function automatic int unsigned scan_latency(input int unsigned chain_len,
                                                 input logic        with_preset);
        return (2 * chain_len) + 32'd3 + (with_preset ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/scan_bit_cnt.sv
// Clear/enable up-counter that stops at CHAIN_LEN-1 and flags the last bit.
module scan_bit_cnt #(
    parameter  int unsigned CHAIN_LEN = 8,
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o = (cnt_q == CNT_W'(CHAIN_LEN - 1));

    // Next count: clear wins, otherwise count up and hold at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !last_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: optional preset, serial load, one capture, serial unload.
// Build option SCAN_CMP_EN adds an expected-value input and a registered
// mismatch flag that is updated together with the result.
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = SCAN_CHAIN_LEN_DEF
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 start,
    input  logic                 preset,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic                 SO,
`ifdef SCAN_CMP_EN
    input  logic [CHAIN_LEN-1:0] expect_i,
    output logic                 fail,
`endif
    output logic                 SE,
    output logic                 SI,
    output logic                 SN_O,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] result
);

    scan_state_e          state_q, state_d;
    logic [CHAIN_LEN-1:0] sh_q, sh_d;
    logic [CHAIN_LEN-1:0] cap_q, cap_d;
    logic [CHAIN_LEN-1:0] res_q, res_d;
    logic                 se_q, se_d;
    logic                 si_q, si_d;
    logic                 sn_q, sn_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cnt_clr, cnt_en, cnt_last;
`ifdef SCAN_CMP_EN
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic                 fail_q, fail_d;
`endif

    scan_bit_cnt #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_bit_cnt (
        .clk    (CK),
        .rst_n  (RN),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .last_o (cnt_last)
    );

    // Next state, data path and output values derived from the next state.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cap_d   = cap_q;
        res_d   = res_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef SCAN_CMP_EN
        exp_d   = exp_q;
        fail_d  = fail_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_d    = pattern;
                    cnt_clr = 1'b1;
                    state_d = preset ? ST_PRESET : ST_SHIFT;
`ifdef SCAN_CMP_EN
                    exp_d   = expect_i;
`endif
                end
            end
            ST_PRESET: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                cnt_en = 1'b1;
                sh_d   = {sh_q[CHAIN_LEN-2:0], 1'b0};
                if (cnt_last) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                cnt_clr = 1'b1;
                state_d = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                cnt_en = 1'b1;
                cap_d  = {cap_q[CHAIN_LEN-2:0], SO};
                if (cnt_last) begin
                    res_d   = cap_d;
                    state_d = ST_DONE;
`ifdef SCAN_CMP_EN
                    fail_d  = (cap_d != exp_q);
`endif
                end
            end
            ST_DONE: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The MSB of the load register is the bit driven during each shift cycle.
        se_d   = (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
        si_d   = (state_d == ST_SHIFT) && sh_d[CHAIN_LEN-1];
        sn_d   = (state_d != ST_PRESET);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, data and output registers; reset aborts any run in progress.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cap_q   <= '0;
            res_q   <= '0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            sn_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cap_q   <= cap_d;
            res_q   <= res_d;
            se_q    <= se_d;
            si_q    <= si_d;
            sn_q    <= sn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SCAN_CMP_EN
    // Expected value and mismatch flag.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            exp_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            exp_q  <= exp_d;
            fail_q <= fail_d;
        end
    end

    assign fail = fail_q;
`endif

    assign SE     = se_q;
    assign SI     = si_q;
    assign SN_O   = sn_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Sequencing controller for a chain of CHAIN_LEN scan flops of the SDFFS_X1 kind.
- Loads a parallel pattern serially through SE/SI, issues one functional capture clock, then unloads the chain through SO into a parallel result register.
- Optionally presets the whole chain through an active-low set line first.
- Sits between the test-access logic and the scan-wrapped datapath.

Parameters:
- CHAIN_LEN, 8, number of flops in the chain (min 2).
- CNT_W, $clog2(CHAIN_LEN), width of the shift bit counter.

Ports:
- CK  input  1  clock; rising-edge active.
- RN  input  1  reset; asynchronous, active-low.
- start  input  1  single-cycle request; sampled only in IDLE.
- preset  input  1  sampled with start; 1 = run PRESET before SHIFT.
- pattern  input  CHAIN_LEN  load pattern, captured into an internal register on accepted start.
- SO  input  1  scan out of the chain tail (stage CHAIN_LEN-1).
- SE  output  1  scan enable to all chain flops.
- SI  output  1  scan in to the chain head (stage 0).
- SN_O  output  1  active-low set to all chain flops.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  CHAIN_LEN  unloaded chain contents; held until the next done.

Behaviour:
- All outputs are registered.
- Reset (RN=0, asynchronous) forces: state IDLE, SE=0, SI=0, SN_O=1, busy=0, done=0, result=0, counter=0.
- Reset asserted mid-operation aborts immediately. No partial result is published.
- States: IDLE, PRESET, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE: on start=1, latch pattern. Go to PRESET if preset=1, else SHIFT. Counter cleared.
- PRESET: exactly 1 cycle. SN_O=0, SE=0. Then go to SHIFT.
- SHIFT: CHAIN_LEN cycles, SE=1. In cycle k (0..CHAIN_LEN-1), SI=pattern[CHAIN_LEN-1-k]. After the last cycle, chain stage i holds pattern[i]. When the counter reaches CHAIN_LEN-1, go to CAPTURE.
- CAPTURE: exactly 1 cycle. SE=0, SI=0, so the chain samples D. Then go to UNLOAD with the counter cleared.
- UNLOAD: CHAIN_LEN cycles, SE=1, SI=0. SO is sampled at the rising edge ending cycle k and written to result[CHAIN_LEN-1-k]. After the last sample, go to DONE.
- DONE: exactly 1 cycle. done=1, SE=0, busy=1. Then go to IDLE.
- Latency from start to done, without preset: 2*CHAIN_LEN+3 cycles (start edge to the done-high cycle). Add 1 cycle with preset.
- start while busy=1 is ignored, not queued. start in the same cycle as done is ignored.
- pattern changes after acceptance have no effect.
- The counter saturates its compare at CHAIN_LEN-1 and never wraps past the chain length.
- SE and SN_O are never both active in the same cycle.

Optional Feature:
- Macro: SCAN_CMP_EN.
- When defined, add input expect (CHAIN_LEN) and output fail (1).
  - expect is latched at start.
  - fail is registered and updates in the DONE cycle to (result != expect).
  - fail holds its value until the next DONE. Reset value 0.
- When undefined, neither port exists and the comparison logic is absent. All other behaviour is identical.

Decomposition:
- Package scan_ctrl_pkg holds:
  - the state enum (IDLE, PRESET, SHIFT, CAPTURE, UNLOAD, DONE);
  - the default CHAIN_LEN;
  - the latency constant function.
- Sub-module scan_bit_cnt: clear/enable up-counter, CNT_W bits, with a terminal flag at CHAIN_LEN-1. It is reused by SHIFT and UNLOAD.

Test Plan:
- Reset: RN=0 mid-SHIFT with CHAIN_LEN=8 -> next sample shows SE=0, SI=0, SN_O=1, busy=0, result=8'h00. No done pulse follows.
- Loopback: SO tied to the chain tail of 8 behavioural SDFFS models with D=~Q. start with pattern=8'hA5, preset=0 -> SI sequence 1,0,1,0,0,1,0,1. Capture inverts the chain; result=8'h5A. done pulses at cycle 19 after start.
- Preset: same chain, start with preset=1, pattern=8'h00 -> SN_O low for exactly 1 cycle, then SHIFT. result=8'hFF. done at cycle 20.
- Ignored start: start re-asserted during SHIFT and in the DONE cycle -> no restart. Exactly one done pulse per accepted start.
- Back-to-back runs: 8'h0F then 8'hF0 -> result holds 8'hF0 between the two done pulses, then 8'h0F.
- With SCAN_CMP_EN: expect=8'h5A, pattern=8'hA5 -> fail=0. expect=8'h00 -> fail=1 in the DONE cycle, held until the next DONE.
